if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It drives the PC, issues instruction-memory addresses, and latches the fetched instruction. It directly consumes the stall, PC-write, IF/ID-write and flush controls from the hazard detection unit. It also feeds the IF/ID source-register fields back to that unit.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: bubble instruction (addi x0,x0,0) inserted on reset or flush.
- XLEN, 32: PC and instruction width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- PCWrite  in  1  1 = PC may advance. 0 = hold PC (load-use stall).
- IF_ID_Write  in  1  1 = IF/ID register may load. 0 = hold.
- Flush  in  1  squash the IF/ID contents and redirect the PC.
- BranchTarget  in  XLEN  redirect address, valid when Flush=1.
- imem_addr  out  XLEN  instruction-memory address (= PC), combinational.
- imem_rdata  in  XLEN  instruction word; combinational read of imem_addr within the same cycle.
- PC_out  out  XLEN  current PC.
- IF_ID_PC  out  XLEN  PC of the instruction held in IF/ID.
- IF_ID_Instr  out  XLEN  instruction held in IF/ID.
- IF_ID_Valid  out  1  1 = real instruction. 0 = bubble.
- IF_ID_RegisterRs1  out  5  IF_ID_Instr[19:15].
- IF_ID_RegisterRs2  out  5  IF_ID_Instr[24:20].

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-stall or mid-flush):
  - PC = RESET_PC.
  - IF_ID_PC = 0, IF_ID_Instr = NOP_INSTR, IF_ID_Valid = 0.
- First fetch happens on the first rising edge after reset deasserts.
- PC update at each rising edge, in priority order:
  1. Flush=1: PC <= {BranchTarget[XLEN-1:2], 2'b00}. Flush overrides PCWrite=0.
  2. PCWrite=1: PC <= PC + 4, with modulo 2^XLEN wrap (32'hFFFF_FFFC -> 0).
  3. Otherwise PC holds.
- IF/ID update at each rising edge, in priority order:
  1. Flush=1: IF_ID_Instr <= NOP_INSTR, IF_ID_Valid <= 0, IF_ID_PC <= PC. Flush overrides IF_ID_Write=0.
  2. IF_ID_Write=1: IF_ID_Instr <= imem_rdata, IF_ID_PC <= PC, IF_ID_Valid <= 1.
  3. Otherwise hold all three fields.
- Latency: an instruction fetched at PC in cycle N appears in IF/ID in cycle N+1. A redirect taking effect at edge N fetches the target in cycle N+1, and that instruction reaches IF/ID in cycle N+2.
- Mixed controls, not generated by the HDU, with defined behaviour:
  - PCWrite=1, IF_ID_Write=0: PC advances and the IF/ID contents hold. The fetched word is dropped.
  - PCWrite=0, IF_ID_Write=1: the same PC/instruction is re-latched.
- Rs1/Rs2 outputs are pure bit slices of IF_ID_Instr. On a bubble they read 0.
- No X propagation: all registers are defined after reset.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds three 32-bit wrapping counters, each zeroed on reset, each exposed as an extra output port.
  - fetch_cnt: increments on edges where IF/ID loads a valid instruction.
  - stall_cnt: increments on edges where PCWrite=0 and Flush=0.
  - flush_cnt: increments on edges where Flush=1.
- Undefined: the counters and their ports are absent. Functional behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - XLEN, NOP_INSTR, RESET_PC constants.
  - RS1_LSB=15 and RS2_LSB=20 field positions.
  - An IF/ID bundle typedef (pc, instr, valid).
- One natural sub-module: pc_reg. It holds the PC register, the +4 adder and the redirect/hold priority mux. The IF/ID register stays inline.

Test Plan:
- Reset release, PCWrite=1, IF_ID_Write=1, memory returns addr^32'hA5A5_0000. Required:
  - PC sequence 0, 4, 8.
  - IF_ID_Instr lags PC by one cycle.
  - IF_ID_Valid rises one edge after reset release.
- Load-use stall: PCWrite=0, IF_ID_Write=0 for 1 cycle at PC=8. Required: PC holds 8; IF_ID holds the PC=4 instruction; both resume next cycle.
- Flush with BranchTarget=32'h0000_0103 while PCWrite=0. Required:
  - PC=32'h100 (low bits cleared, flush overrides the stall).
  - IF_ID_Instr=32'h0000_0013, Valid=0.
  - Target instruction appears in IF/ID two edges later.
- Wrap: RESET_PC=32'hFFFF_FFF8, free-run. Required: PC FFFF_FFF8 -> FFFF_FFFC -> 0000_0000.
- Reset asserted asynchronously mid-cycle during a stall. Required: PC=RESET_PC and Valid=0 before the next clock edge.
- IF_PERF_CNT_EN: 5 fetch cycles, 2 stall cycles, 1 flush. Required: fetch_cnt=5, stall_cnt=2, flush_cnt=1.

Source files
------------

// File: rtl/if_id_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its IF/ID register.
package if_id_fetch_stage_pkg;

  localparam int XLEN = 32;

  // Defaults for the stage's RESET_PC / NOP_INSTR parameters.
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013; // addi x0,x0,0

  // Source-register field positions inside an instruction word.
  localparam int REG_ADDR_W = 5;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Fetch-stage bundle: hazard controls, instruction-memory port and IF/ID view.
// Optional performance counters appear when IF_PERF_CNT_EN is defined.
interface if_id_fetch_stage_if;
  import if_id_fetch_stage_pkg::*;

  // Hazard-unit controls
  logic                  PCWrite;
  logic                  IF_ID_Write;
  logic                  Flush;
  logic [XLEN-1:0]       BranchTarget;

  // Instruction memory (combinational read)
  logic [XLEN-1:0]       imem_addr;
  logic [XLEN-1:0]       imem_rdata;

  // Stage outputs
  logic [XLEN-1:0]       PC_out;
  logic [XLEN-1:0]       IF_ID_PC;
  logic [XLEN-1:0]       IF_ID_Instr;
  logic                  IF_ID_Valid;
  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs1;
  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs2;

`ifdef IF_PERF_CNT_EN
  logic [31:0]           fetch_cnt;
  logic [31:0]           stall_cnt;
  logic [31:0]           flush_cnt;
`endif

  // Fetch stage side
  modport master (
    input  PCWrite, IF_ID_Write, Flush, BranchTarget, imem_rdata,
`ifdef IF_PERF_CNT_EN
    output fetch_cnt, stall_cnt, flush_cnt,
`endif
    output imem_addr, PC_out, IF_ID_PC, IF_ID_Instr, IF_ID_Valid,
    output IF_ID_RegisterRs1, IF_ID_RegisterRs2
  );

  // Hazard unit / memory / decode side
  modport slave (
    output PCWrite, IF_ID_Write, Flush, BranchTarget, imem_rdata,
`ifdef IF_PERF_CNT_EN
    input  fetch_cnt, stall_cnt, flush_cnt,
`endif
    input  imem_addr, PC_out, IF_ID_PC, IF_ID_Instr, IF_ID_Valid,
    input  IF_ID_RegisterRs1, IF_ID_RegisterRs2
  );

endinterface

// File: rtl/if_id_fetch_stage_pc_reg.sv
// Program counter: redirect beats advance, advance beats hold.
module if_id_fetch_stage_pc_reg #(
  parameter logic [if_id_fetch_stage_pkg::XLEN-1:0] RESET_PC =
    if_id_fetch_stage_pkg::DEFAULT_RESET_PC
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  pc_write,
  input  logic                                  flush,
  input  logic [if_id_fetch_stage_pkg::XLEN-1:0] branch_target,
  output logic [if_id_fetch_stage_pkg::XLEN-1:0] pc
);
  import if_id_fetch_stage_pkg::*;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Next-PC selection: word-aligned redirect, sequential +4 (wraps), or hold.
  always_comb begin
    // NOTE: default first so every path assigns pc_d and no latch is inferred.
    pc_d = pc_q;
    if (flush) begin
      pc_d = {branch_target[XLEN-1:2], 2'b00};
    end else if (pc_write) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // PC register with asynchronous reset to the boot address.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Optional feature macro: IF_PERF_CNT_EN (fetch/stall/flush counters).
module if_id_fetch_stage #(
  parameter logic [if_id_fetch_stage_pkg::XLEN-1:0] RESET_PC  =
    if_id_fetch_stage_pkg::DEFAULT_RESET_PC,
  parameter logic [if_id_fetch_stage_pkg::XLEN-1:0] NOP_INSTR =
    if_id_fetch_stage_pkg::DEFAULT_NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 reset,
  if_id_fetch_stage_if.master  bus
);
  import if_id_fetch_stage_pkg::*;

  logic [XLEN-1:0] pc;
  if_id_t          if_id_q;

  if_id_fetch_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (bus.PCWrite),
    .flush         (bus.Flush),
    .branch_target (bus.BranchTarget),
    .pc            (pc)
  );

  assign bus.imem_addr = pc;
  assign bus.PC_out    = pc;

  // IF/ID register: flush inserts a bubble, otherwise load or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (bus.Flush) begin
      if_id_q <= '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
    end else if (bus.IF_ID_Write) begin
      if_id_q <= '{pc: pc, instr: bus.imem_rdata, valid: 1'b1};
    end
  end

  assign bus.IF_ID_PC          = if_id_q.pc;
  assign bus.IF_ID_Instr       = if_id_q.instr;
  assign bus.IF_ID_Valid       = if_id_q.valid;
  // The bubble encoding has zero register fields, so these read 0 on a bubble.
  assign bus.IF_ID_RegisterRs1 = if_id_q.instr[RS1_LSB +: REG_ADDR_W];
  assign bus.IF_ID_RegisterRs2 = if_id_q.instr[RS2_LSB +: REG_ADDR_W];

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Event counters: valid IF/ID loads, PC stalls without redirect, flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!bus.Flush && bus.IF_ID_Write) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!bus.Flush && !bus.PCWrite)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.Flush)                     flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt = fetch_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed vector table, wrap,
// asynchronous reset, randomized run against a behavioural model, and
// (with IF_PERF_CNT_EN) the performance counters.
module tb_if_id_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] MEMKEY = 32'hA5A5_0000;

  logic clk;
  logic reset;

  if_id_fetch_stage_if bus();
  if_id_fetch_stage_if bus_w();

  if_id_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ MEMKEY;
  endfunction

  assign bus.imem_rdata   = mem_word(bus.imem_addr);
  assign bus_w.imem_rdata = mem_word(bus_w.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_ifid_pc, m_instr;
  logic        m_valid;
  int          m_fetches, m_stalls, m_flushes;

  task automatic model_reset(input logic [31:0] rpc);
    m_pc = rpc; m_ifid_pc = 32'h0; m_instr = NOP; m_valid = 1'b0;
    m_fetches = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // One clock edge of the stage, computed from the old state as a whole.
  task automatic model_edge(input logic pcw, input logic ifw, input logic fl,
                            input logic [31:0] bt);
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (fl) begin
      m_ifid_pc = old_pc; m_instr = NOP; m_valid = 1'b0;
      m_pc = (bt / 4) * 4;
      m_flushes++;
    end else begin
      if (ifw) begin
        m_ifid_pc = old_pc; m_instr = mem_word(old_pc); m_valid = 1'b1;
        m_fetches++;
      end
      if (pcw) m_pc = 32'((64'(old_pc) + 64'd4) % 64'h1_0000_0000);
      else     m_stalls++;
    end
  endtask

  task automatic compare_model(input string tag);
    logic [31:0] mi;
    mi = m_instr;
    check({tag, ".pc"},      bus.PC_out,      m_pc);
    check({tag, ".addr"},    bus.imem_addr,   m_pc);
    check({tag, ".ifid_pc"}, bus.IF_ID_PC,    m_ifid_pc);
    check({tag, ".instr"},   bus.IF_ID_Instr, m_instr);
    check({tag, ".valid"},   32'(bus.IF_ID_Valid), 32'(m_valid));
    check({tag, ".rs1"},     32'(bus.IF_ID_RegisterRs1), 32'(mi[19:15]));
    check({tag, ".rs2"},     32'(bus.IF_ID_RegisterRs2), 32'(mi[24:20]));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic pcw, input logic ifw, input logic fl, input logic [31:0] bt);
    bus.PCWrite = pcw; bus.IF_ID_Write = ifw; bus.Flush = fl; bus.BranchTarget = bt;
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic pcw, input logic ifw, input logic fl, input logic [31:0] bt);
    drive(pcw, ifw, fl, bt);
    @(posedge clk);
    model_edge(pcw, ifw, fl, bt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset(32'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        pcw, ifw, fl;
    logic [31:0] bt;
    logic [31:0] pc, ifid_pc, instr;
    logic        valid;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ins;
    //                pcw  ifw  fl   bt            pc            ifid_pc       instr         valid
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0004, 32'h0000_0000, 32'hA5A5_0000, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0008, 32'h0000_0004, 32'hA5A5_0004, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0008, 32'h0000_0004, 32'hA5A5_0004, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_000C, 32'h0000_0008, 32'hA5A5_0008, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0000_0103, 32'h0000_0100, 32'h0000_000C, 32'h0000_0013, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0104, 32'h0000_0100, 32'hA5A5_0100, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_0108, 32'h0000_0100, 32'hA5A5_0100, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0108, 32'h0000_0108, 32'hA5A5_0108, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h0000_0202, 32'h0000_0200, 32'h0000_0108, 32'h0000_0013, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0204, 32'h0000_0200, 32'hA5A5_0200, 1'b1};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    bus_w.PCWrite = 1'b1; bus_w.IF_ID_Write = 1'b1; bus_w.Flush = 1'b0; bus_w.BranchTarget = 32'h0;

    // Wrap: second instance boots at FFFF_FFF8 and free-runs.
    do_reset();
    check("wrap.pc0", bus_w.PC_out, 32'hFFFF_FFF8);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap.pc1", bus_w.PC_out, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap.pc2", bus_w.PC_out, 32'h0000_0000);
    check("wrap.ifid_pc", bus_w.IF_ID_PC, 32'hFFFF_FFFC);
    check("wrap.instr", bus_w.IF_ID_Instr, 32'h5A5A_FFFC);

    // Reset state, then the directed table.
    do_reset();
    check("rst.pc",      bus.PC_out,      32'h0);
    check("rst.ifid_pc", bus.IF_ID_PC,    32'h0);
    check("rst.instr",   bus.IF_ID_Instr, NOP);
    check("rst.valid",   32'(bus.IF_ID_Valid), 32'h0);
    check("rst.rs1",     32'(bus.IF_ID_RegisterRs1), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].pcw, vecs[i].ifw, vecs[i].fl, vecs[i].bt);
      ins = vecs[i].instr;
      check($sformatf("vec%0d.pc", i),      bus.PC_out,      vecs[i].pc);
      check($sformatf("vec%0d.ifid_pc", i), bus.IF_ID_PC,    vecs[i].ifid_pc);
      check($sformatf("vec%0d.instr", i),   bus.IF_ID_Instr, vecs[i].instr);
      check($sformatf("vec%0d.valid", i),   32'(bus.IF_ID_Valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d.rs1", i),     32'(bus.IF_ID_RegisterRs1), 32'(ins[19:15]));
      check($sformatf("vec%0d.rs2", i),     32'(bus.IF_ID_RegisterRs2), 32'(ins[24:20]));
    end

    // Asynchronous reset mid-cycle during a stall.
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("arst.pre_pc", bus.PC_out, 32'h0000_000C);
    #2 reset = 1'b1;
    #1;
    check("arst.pc",      bus.PC_out,      32'h0);
    check("arst.valid",   32'(bus.IF_ID_Valid), 32'h0);
    check("arst.instr",   bus.IF_ID_Instr, NOP);
    check("arst.ifid_pc", bus.IF_ID_PC,    32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset(32'h0);

`ifdef IF_PERF_CNT_EN
    // Counters: 5 fetches, 2 stalls, 1 flush.
    do_reset();
    check("perf.rst_fetch", bus.fetch_cnt, 32'd0);
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    check("perf.fetch", bus.fetch_cnt, 32'd5);
    check("perf.stall", bus.stall_cnt, 32'd2);
    check("perf.flush", bus.flush_cnt, 32'd1);
`endif

    // Randomized controls against the behavioural model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic pcw, ifw, fl;
      logic [31:0] bt;
      pcw = ($urandom_range(0, 9) < 8);
      ifw = ($urandom_range(0, 9) < 8);
      fl  = ($urandom_range(0, 9) == 0);
      bt  = $urandom;
      step(pcw, ifw, fl, bt);
      compare_model($sformatf("rnd%0d", c));
    end
`ifdef IF_PERF_CNT_EN
    check("rnd.fetch_cnt", bus.fetch_cnt, 32'(m_fetches));
    check("rnd.stall_cnt", bus.stall_cnt, 32'(m_stalls));
    check("rnd.flush_cnt", bus.flush_cnt, 32'(m_flushes));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
